// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: datapath widths and the MEM/WB pipeline bundle.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] alures;
        logic [DATA_W-1:0] rdata;
    } memwb_t;

    localparam memwb_t MEMWB_NOP = '0;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: one synchronous write port, one combinational read port.
// The whole array clears on reset so no stale data survives a pipeline restart.
module data_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read sees the pre-write word; a same-edge store lands after capture.
    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: alignment check, store gating, data memory and the MEM/WB register.
// Flush beats stall; a stall holds MEM/WB but never lets align_err linger.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] EX_MEMALUres,
    input  logic [DATA_W-1:0] EX_MEMWdata,
    input  logic [REG_AW-1:0] EX_MEMRd,
    input  logic              EX_MEMRegWrite,
    input  logic              EX_MEMMemtoReg,
    input  logic              EX_MEMMemRead,
    input  logic              EX_MEMMemWrite,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] Rdata,
    output logic [DATA_W-1:0] ALUres,
    output logic [REG_AW-1:0] MEM_WBRd,
    output logic              RegWrite,
    output logic              MemtoReg,
    output logic              align_err
);

    logic              mis;
    logic              we;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] ld_data;
    memwb_t            memwb_q;
    memwb_t            memwb_d;

    assign idx = EX_MEMALUres[AW+1:2];
    assign mis = (EX_MEMMemRead | EX_MEMMemWrite) & (EX_MEMALUres[1:0] != 2'b00);
    assign we  = EX_MEMMemWrite & ~mis & ~stall & ~flush;

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .idx   (idx),
        .wdata (EX_MEMWdata),
        .rdata (mem_rdata)
    );

    // Misaligned loads and non-loads deliver zero so WB never sees garbage.
    assign ld_data = (EX_MEMMemRead & ~mis) ? mem_rdata : '0;

    always_comb begin
        memwb_d          = MEMWB_NOP;
        memwb_d.rd       = EX_MEMRd;
        memwb_d.regwrite = EX_MEMRegWrite;
        memwb_d.memtoreg = EX_MEMMemtoReg;
        memwb_d.alures   = EX_MEMALUres;
        memwb_d.rdata    = ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_q   <= MEMWB_NOP;
            align_err <= 1'b0;
        end else if (flush) begin
            memwb_q   <= MEMWB_NOP;
            align_err <= 1'b0;
        end else if (stall) begin
            align_err <= 1'b0;
        end else begin
            memwb_q   <= memwb_d;
            align_err <= mis;
        end
    end

    assign Rdata    = memwb_q.rdata;
    assign ALUres   = memwb_q.alures;
    assign MEM_WBRd = memwb_q.rd;
    assign RegWrite = memwb_q.regwrite;
    assign MemtoReg = memwb_q.memtoreg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic
// compared every cycle against a word-array reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] EX_MEMALUres = '0;
    logic [31:0] EX_MEMWdata = '0;
    logic [3:0]  EX_MEMRd = '0;
    logic        EX_MEMRegWrite = 1'b0;
    logic        EX_MEMMemtoReg = 1'b0;
    logic        EX_MEMMemRead = 1'b0;
    logic        EX_MEMMemWrite = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] Rdata;
    logic [31:0] ALUres;
    logic [3:0]  MEM_WBRd;
    logic        RegWrite;
    logic        MemtoReg;
    logic        align_err;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .EX_MEMALUres   (EX_MEMALUres),
        .EX_MEMWdata    (EX_MEMWdata),
        .EX_MEMRd       (EX_MEMRd),
        .EX_MEMRegWrite (EX_MEMRegWrite),
        .EX_MEMMemtoReg (EX_MEMMemtoReg),
        .EX_MEMMemRead  (EX_MEMMemRead),
        .EX_MEMMemWrite (EX_MEMMemWrite),
        .stall          (stall),
        .flush          (flush),
        .Rdata          (Rdata),
        .ALUres         (ALUres),
        .MEM_WBRd       (MEM_WBRd),
        .RegWrite       (RegWrite),
        .MemtoReg       (MemtoReg),
        .align_err      (align_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] ref_mem [64];
    logic [31:0] e_rdata, e_alures;
    logic [3:0]  e_rd;
    logic        e_rw, e_m2r, e_ae;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        e_rdata = '0; e_alures = '0; e_rd = '0; e_rw = 0; e_m2r = 0; e_ae = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Rdata"},    Rdata,            e_rdata);
        chk({tag, ".ALUres"},   ALUres,           e_alures);
        chk({tag, ".Rd"},       {28'h0, MEM_WBRd}, {28'h0, e_rd});
        chk({tag, ".RegWrite"}, {31'h0, RegWrite}, {31'h0, e_rw});
        chk({tag, ".MemtoReg"}, {31'h0, MemtoReg}, {31'h0, e_m2r});
        chk({tag, ".align_err"},{31'h0, align_err},{31'h0, e_ae});
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] rd,
                         input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic st, input logic fl);
        EX_MEMALUres = alu; EX_MEMWdata = wd; EX_MEMRd = rd;
        EX_MEMRegWrite = rw; EX_MEMMemtoReg = m2r;
        EX_MEMMemRead = mr; EX_MEMMemWrite = mw;
        stall = st; flush = fl;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one edge, update the model from the inputs present at that edge, then check.
    task automatic tick(input string tag);
        int unsigned idx;
        logic mis;
        logic [31:0] ld;
        @(posedge clk);
        idx = (EX_MEMALUres / 4) % 64;
        mis = (EX_MEMMemRead || EX_MEMMemWrite) && (EX_MEMALUres % 4 != 0);
        ld  = (EX_MEMMemRead && !mis) ? ref_mem[idx] : 32'h0;
        if (flush) begin
            e_rdata = '0; e_alures = '0; e_rd = '0; e_rw = 0; e_m2r = 0; e_ae = 0;
        end else if (stall) begin
            e_ae = 0;
        end else begin
            e_rdata = ld; e_alures = EX_MEMALUres; e_rd = EX_MEMRd;
            e_rw = EX_MEMRegWrite; e_m2r = EX_MEMMemtoReg; e_ae = mis;
        end
        if (EX_MEMMemWrite && !mis && !stall && !flush) ref_mem[idx] = EX_MEMWdata;
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b1;
        @(posedge clk); #1;
        check_all("rst_init");

        // Reset asserted mid-stream
        drive(32'h20, 32'h11112222, 4'h2, 1, 0, 0, 1, 0, 0);
        tick("pre_rst_st");
        drive(32'h24, 32'h0, 4'h6, 1, 0, 0, 0, 0, 0);
        tick("pre_rst_alu");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk); rst = 1'b1;
        drive(32'h10, 32'h0, 4'h9, 1, 1, 1, 0, 0, 0);
        tick("rst_ld10");
        chk("rst_ld10_val", Rdata, 32'h0);
        chk("rst_ld10_rd", {28'h0, MEM_WBRd}, 32'h9);
        drive(32'h20, 32'h0, 4'h9, 1, 1, 1, 0, 0, 0);
        tick("rst_ld20");
        chk("rst_ld20_cleared", Rdata, 32'h0);

        // Store then load back-to-back
        drive(32'h08, 32'hDEADBEEF, 4'h0, 0, 0, 0, 1, 0, 0);
        tick("st08");
        drive(32'h08, 32'h0, 4'h5, 1, 1, 1, 0, 0, 0);
        tick("ld08");
        chk("stld_rdata", Rdata, 32'hDEADBEEF);
        chk("stld_rd", {28'h0, MEM_WBRd}, 32'h5);
        chk("stld_ctl", {30'h0, RegWrite, MemtoReg}, 32'h3);

        // Wrap-around
        drive(32'h100, 32'h12345678, 4'h0, 0, 0, 0, 1, 0, 0);
        tick("st100");
        drive(32'h000, 32'h0, 4'h1, 1, 1, 1, 0, 0, 0);
        tick("ld000");
        chk("wrap_rdata", Rdata, 32'h12345678);

        // Misaligned store then nop, then load of the aligned word
        drive(32'h0A, 32'hAAAAAAAA, 4'h0, 0, 0, 0, 1, 0, 0);
        tick("mis_st");
        chk("mis_ae_hi", {31'h0, align_err}, 32'h1);
        nop();
        tick("mis_nop");
        chk("mis_ae_lo", {31'h0, align_err}, 32'h0);
        drive(32'h08, 32'h0, 4'h5, 1, 1, 1, 0, 0, 0);
        tick("mis_ld08");
        chk("mis_unchanged", Rdata, 32'hDEADBEEF);
        drive(32'h0A, 32'h0, 4'h5, 1, 1, 1, 0, 0, 0);
        tick("mis_ld0a");
        chk("mis_ld_zero", Rdata, 32'h0);

        // Stall on a store for 3 cycles, then squash it: memory must be untouched
        for (int i = 0; i < 3; i++) begin
            drive(32'h04, 32'h55, 4'h0, 0, 0, 0, 1, 1, 0);
            tick("stall_st");
            chk("stall_frozen", Rdata, 32'h0);
        end
        drive(32'h04, 32'h55, 4'h0, 0, 0, 0, 1, 0, 1);
        tick("stall_squash");
        drive(32'h04, 32'h0, 4'h7, 1, 1, 1, 0, 0, 0);
        tick("stall_ld04a");
        chk("stall_nowrite", Rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(32'h04, 32'h55, 4'h0, 0, 0, 0, 1, 1, 0);
            tick("stall2_st");
        end
        drive(32'h04, 32'h55, 4'h0, 0, 0, 0, 1, 0, 0);
        tick("stall_rel");
        chk("stall_adv", ALUres, 32'h04);
        drive(32'h04, 32'h0, 4'h7, 1, 1, 1, 0, 0, 0);
        tick("stall_ld04b");
        chk("stall_write", Rdata, 32'h55);

        // Flush beats stall
        drive(32'h7, 32'h0, 4'h3, 1, 0, 0, 0, 1, 1);
        tick("fl_st");
        chk("fl_rw", {31'h0, RegWrite}, 32'h0);
        chk("fl_alu", ALUres, 32'h0);

        // Simultaneous read+write returns the pre-write word
        drive(32'h04, 32'h99, 4'h4, 1, 1, 1, 1, 0, 0);
        tick("rw_both");
        chk("rw_both_old", Rdata, 32'h55);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic mr, mw;
            int r;
            a = ($urandom_range(0, 3) == 0) ? $urandom() : {22'h0, 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            r  = $urandom_range(0, 15);
            mr = (r < 6) || (r == 15);
            mw = (r >= 6 && r < 12) || (r == 15);
            drive(a, $urandom(), 4'($urandom()), 1'($urandom()), 1'($urandom()), mr, mw,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
